alu_register_file: RTL
======================

Name: alu_register_file

Overview:
- Operand source for the 16-bit ALU. Holds 4 general registers (R1-R4) and 4 scratch registers (S1-S4).
- Each register applies a per-cycle micro-operation selected by FunSel; several registers can be written in the same cycle.
- Two read ports, OutA and OutB, drive the ALU A and B inputs directly.
- The ALU result (ALUOut) returns to input I, closing the datapath loop.

Parameters:
- DATA_W, 16, register and bus width; must be even, and 16 is the validated value.
- RST_VAL, 0, value loaded into every register on reset.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- I  in  DATA_W  write data, normally ALUOut.
- FunSel  in  3  micro-operation applied to every enabled register.
- RegSel  in  4  per-register write enable, bit3=R1 … bit0=R4, active-high.
- ScrSel  in  4  per-register write enable, bit3=S1 … bit0=S4, active-high.
- OutASel  in  3  read select A: 000-011 = R1-R4, 100-111 = S1-S4.
- OutBSel  in  3  read select B, same encoding as OutASel.
- OutA  out  DATA_W  combinational read of the selected register.
- OutB  out  DATA_W  combinational read of the selected register.

Behaviour:
- Reset low, asynchronous: all 8 registers = RST_VAL immediately, so OutA and OutB = RST_VAL. Reset dominates any in-flight write; the first update after release occurs on the first rising Clock edge with Reset high.
- Registers with an enable bit of 0 hold their value. All enabled registers apply the same FunSel on the edge.
- FunSel encoding, H = high byte, L = low byte:
  - 000: R ← R − 1, wraps 0x0000 → 0xFFFF.
  - 001: R ← R + 1, wraps 0xFFFF → 0x0000.
  - 010: R ← I.
  - 011: R ← 0.
  - 100: R ← {8'h00, I[7:0]}.
  - 101: R ← {R[15:8], I[7:0]}, high byte kept.
  - 110: R ← {I[7:0], R[7:0]}, low byte placed in the high byte, low byte kept.
  - 111: R ← {{8{I[7]}}, I[7:0]}, sign-extend.
- Reads are combinational from current state. There is no read-during-write bypass: when a register is read and written in the same cycle, OutA/OutB show the pre-edge value and the new value appears after the edge. This makes the ALU → I → register loop single-cycle with no combinational path from I to OutA/OutB.
- OutASel and OutBSel may select the same register; both ports then show the same value.
- RegSel = ScrSel = 0: no state change for any FunSel, including 011.
- Arithmetic is modulo 2^DATA_W. No flags are produced; flags belong to the ALU.
- X or Z on select inputs is not specified. Bench constrains selects to known values.

Optional Feature:
- Macro REGFILE_SATURATE_EN.
- Defined: FunSel 000 at 0x0000 holds 0x0000, and FunSel 001 at 0xFFFF holds 0xFFFF (saturating). All other codes unchanged.
- Undefined: wrap-around as specified above.

Test Plan:
1. Reset=0 mid-cycle with RegSel=1111, FunSel=001 → all registers read 0x0000 at once, and they stay 0 until Reset=1 plus one edge, after which they read 0x0001.
2. I=0x12F0, RegSel=1000, FunSel=010, edge → R1=0x12F0. Then FunSel=110, I=0x00AB, edge → R1=0xABF0. Then FunSel=101, I=0x0034, edge → R1=0xAB34.
3. I=0x0080, ScrSel=0100, FunSel=111 → S2=0xFF80. With FunSel=100 → S2=0x0080.
4. R3=0xFFFF, FunSel=001 → R3=0x0000; macro defined → stays 0xFFFF. R3=0x0000, FunSel=000 → 0xFFFF; macro defined → stays 0x0000.
5. OutASel=000, OutBSel=000, R1=0x0005, FunSel=001 on R1: before edge OutA=OutB=0x0005, after edge both 0x0006. Non-selected registers unchanged.
6. RegSel=0000, ScrSel=0000, FunSel=011 for 4 cycles → all 8 registers retain their preloaded distinct values (0x1111 … 0x8888).

Source files
------------

// File: rtl/alu_register_file.sv
// Eight-entry operand register file (R1-R4, S1-S4) for the 16-bit ALU.
// Optional macro REGFILE_SATURATE_EN makes the increment and decrement operations saturate.
module alu_register_file #(
    parameter int unsigned       DATA_W  = 16,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] I,
    input  logic [2:0]        FunSel,
    input  logic [3:0]        RegSel,
    input  logic [3:0]        ScrSel,
    input  logic [2:0]        OutASel,
    input  logic [2:0]        OutBSel,
    output logic [DATA_W-1:0] OutA,
    output logic [DATA_W-1:0] OutB
);

    localparam int unsigned       Half = DATA_W / 2;
    localparam logic [DATA_W-1:0] One  = DATA_W'(1);

    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] regs_d [8];
    logic [7:0]        wr_en;

    // Index 0-3 = R1-R4, 4-7 = S1-S4; the select buses list R1/S1 in their MSB.
    assign wr_en = {ScrSel[0], ScrSel[1], ScrSel[2], ScrSel[3],
                    RegSel[0], RegSel[1], RegSel[2], RegSel[3]};

    function automatic logic [DATA_W-1:0] micro_op(input logic [DATA_W-1:0] cur,
                                                    input logic [DATA_W-1:0] din,
                                                    input logic [2:0]        fs);
        logic [DATA_W-1:0] res;
        res = cur;
        unique case (fs)
`ifdef REGFILE_SATURATE_EN
            3'b000: res = (cur == '0) ? cur : cur - One;
            3'b001: res = (cur == '1) ? cur : cur + One;
`else
            3'b000: res = cur - One;
            3'b001: res = cur + One;
`endif
            3'b010: res = din;
            3'b011: res = '0;
            3'b100: res = {{Half{1'b0}}, din[Half-1:0]};
            3'b101: res = {cur[DATA_W-1:Half], din[Half-1:0]};
            3'b110: res = {din[Half-1:0], cur[Half-1:0]};
            3'b111: res = {{Half{din[Half-1]}}, din[Half-1:0]};
        endcase
        return res;
    endfunction

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            regs_d[k] = regs_q[k];
            if (wr_en[k]) begin
                regs_d[k] = micro_op(regs_q[k], I, FunSel);
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int k = 0; k < 8; k++) begin
                regs_q[k] <= RST_VAL;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    // No write bypass: reads always reflect pre-edge state.
    assign OutA = regs_q[OutASel];
    assign OutB = regs_q[OutBSel];

endmodule
